// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous SRAM between two requesters.
//   Port 0 is the AXI slave's memory interface and port 1 is a background
//   engine. One access is issued per cycle. Grants are round-robin, and a
//   requester may lock the grant across a burst. Read data is steered back
//   to the issuing port through a RD_LATENCY-deep {valid, id} tag pipeline.
//
//   Optional feature macro: MEM_ARB_STARVE_EN
//     When defined, each port has a saturating 8-bit counter of cycles spent
//     requesting without a grant. Once the counter reaches STARVE_LIMIT, that
//     port's request breaks the other port's lock.
//
// Ports
//   aclk, areset                   clock, asynchronous active-high reset
//   rN_req/we/lock                 port N request, write/read, hold grant
//   rN_addr/wdata/wstrb            port N access fields
//   rN_gnt                         port N access accepted this cycle
//   rN_rvalid/rdata                port N read return
//   mem_en/we/addr/wdata/wstrb     SRAM command, driven by the granted port
//   mem_rdata                      SRAM read data, RD_LATENCY cycles after issue
//   arb_owner                      last granted port (reset 1, so port 0 wins first)
//   arb_locked                     lock currently held
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    r0_req,
    input  logic                    r0_we,
    input  logic                    r0_lock,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic [DATA_WIDTH-1:0]   r0_wdata,
    input  logic [DATA_WIDTH/8-1:0] r0_wstrb,
    output logic                    r0_gnt,
    output logic                    r0_rvalid,
    output logic [DATA_WIDTH-1:0]   r0_rdata,
    input  logic                    r1_req,
    input  logic                    r1_we,
    input  logic                    r1_lock,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic [DATA_WIDTH-1:0]   r1_wdata,
    input  logic [DATA_WIDTH/8-1:0] r1_wstrb,
    output logic                    r1_gnt,
    output logic                    r1_rvalid,
    output logic [DATA_WIDTH-1:0]   r1_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    arb_owner,
    output logic                    arb_locked
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255
        || (DATA_WIDTH % 8) != 0) begin : g_param_check
        $error("mem_port_arbiter: parameter out of range");
    end

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t state, state_next;
    logic   owner, owner_next;
    logic   gnt0, gnt1;
    logic   owner_req, owner_lock, granted_lock;

    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_id;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

`ifdef MEM_ARB_STARVE_EN
    logic [7:0] starve_cnt0, starve_cnt1;
    logic       starve0, starve1;

    assign starve0 = int'(starve_cnt0) >= STARVE_LIMIT;
    assign starve1 = int'(starve_cnt1) >= STARVE_LIMIT;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            starve_cnt0 <= '0;
            starve_cnt1 <= '0;
        end else begin
            if (gnt0)
                starve_cnt0 <= '0;
            else if (r0_req && starve_cnt0 != '1)
                starve_cnt0 <= starve_cnt0 + 8'd1;
            if (gnt1)
                starve_cnt1 <= '0;
            else if (r1_req && starve_cnt1 != '1)
                starve_cnt1 <= starve_cnt1 + 8'd1;
        end
    end
`endif

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= UNLOCKED;
            owner <= 1'b1;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // Grant decode. Held at zero during reset so no access escapes while
    // the arbiter state is being cleared.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!areset) begin
            if (state == UNLOCKED) begin
                if (r0_req && r1_req) begin
                    gnt0 = owner;
                    gnt1 = !owner;
                end else begin
                    gnt0 = r0_req;
                    gnt1 = r1_req;
                end
            end else begin
                gnt0 = r0_req && !owner;
                gnt1 = r1_req && owner;
`ifdef MEM_ARB_STARVE_EN
                if (starve0 && r0_req && owner) begin
                    gnt0 = 1'b1;
                    gnt1 = 1'b0;
                end
                if (starve1 && r1_req && !owner) begin
                    gnt1 = 1'b1;
                    gnt0 = 1'b0;
                end
`endif
            end
        end
    end

    assign owner_req    = owner ? r1_req  : r0_req;
    assign owner_lock   = owner ? r1_lock : r0_lock;
    assign granted_lock = gnt1  ? r1_lock : r0_lock;

    // Next state. Any grant (owner access or starvation override) leaves the
    // lock state equal to that access's lock bit.
    always_comb begin
        state_next = state;
        owner_next = owner;
        if (gnt0 || gnt1)
            owner_next = gnt1;
        unique case (state)
            UNLOCKED: begin
                if ((gnt0 || gnt1) && granted_lock)
                    state_next = LOCKED;
            end
            LOCKED: begin
                if (gnt0 || gnt1)
                    state_next = granted_lock ? LOCKED : UNLOCKED;
                else if (!owner_req && !owner_lock)
                    state_next = UNLOCKED;
            end
            default: state_next = UNLOCKED;
        endcase
    end

    // Output decode
    always_comb begin
        mem_en    = gnt0 || gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (gnt0) begin
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
            mem_wstrb = r0_wstrb;
        end else if (gnt1) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
            mem_wstrb = r1_wstrb;
        end
    end

    assign r0_gnt     = gnt0;
    assign r1_gnt     = gnt1;
    assign arb_owner  = owner;
    assign arb_locked = (state == LOCKED);

    // Read tag pipeline: stage 0 is loaded on the issue edge, so the last
    // stage lines up with mem_rdata RD_LATENCY cycles later.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pipe_valid <= '0;
            pipe_id    <= '0;
        end else begin
            pipe_valid[0] <= mem_en && !mem_we;
            pipe_id[0]    <= gnt1;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    assign r0_rvalid = pipe_valid[RD_LATENCY-1] && !pipe_id[RD_LATENCY-1];
    assign r1_rvalid = pipe_valid[RD_LATENCY-1] &&  pipe_id[RD_LATENCY-1];

    // Returned data passes straight through in the valid cycle and is then
    // held so each port keeps its last read value.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (r0_rvalid)
                rdata0_q <= mem_rdata;
            if (r1_rvalid)
                rdata1_q <= mem_rdata;
        end
    end

    assign r0_rdata = r0_rvalid ? mem_rdata : rdata0_q;
    assign r1_rdata = r1_rvalid ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (RD_LATENCY = 2, STARVE_LIMIT = 4).
//   A small SRAM model answers reads with a word derived from the address.
//   A transaction-level reference (owner/lock flags, queue of reads with a
//   due cycle) predicts every output each cycle; literal checks in the
//   stimulus pin key cycles of each scenario.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int LAT  = 2;
    localparam int SLIM = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic          r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic [SW-1:0] r0_wstrb, r1_wstrb;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_wstrb;
    logic          arb_owner, arb_locked;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .STARVE_LIMIT(SLIM)
    ) dut (
        .aclk(aclk), .areset(areset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb), .r0_gnt(r0_gnt),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb), .r1_gnt(r1_gnt),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .arb_owner(arb_owner), .arb_locked(arb_locked)
    );

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM environment model: read data appears LAT cycles after issue.
    logic [LAT-1:0] sp_v = '0;
    logic [AW-1:0]  sp_a [LAT];
    always @(posedge aclk) begin
        sp_v[0] <= mem_en && !mem_we;
        sp_a[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            sp_v[i] <= sp_v[i-1];
            sp_a[i] <= sp_a[i-1];
        end
    end
    assign mem_rdata = sp_v[LAT-1] ? sram_word(sp_a[LAT-1]) : 32'hDEAD_BEEF;

    // Reference model
    typedef struct { int port; logic [31:0] addr; int due; } rd_t;
    rd_t         inflight[$];
    bit          m_locked = 1'b0;
    int          m_owner  = 1;
    int          m_cnt[2] = '{0, 0};
    logic [31:0] m_rdata[2] = '{32'h0, 32'h0};
    int          cyc = 0;
    bit   [1:0]  mreq, mwe, mlock;
    logic [31:0] maddr[2], mwd[2];
    logic [3:0]  mws[2];
    int          w, oth;
    bit   [1:0]  ev;
    logic [31:0] erd[2];

    always @(negedge aclk) begin
        if (areset) begin
            check("rst_r0_gnt", r0_gnt, 0);     check("rst_r1_gnt", r1_gnt, 0);
            check("rst_r0_rvalid", r0_rvalid, 0); check("rst_r1_rvalid", r1_rvalid, 0);
            check("rst_r0_rdata", r0_rdata, 0); check("rst_r1_rdata", r1_rdata, 0);
            check("rst_mem_en", mem_en, 0);     check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0); check("rst_mem_wdata", mem_wdata, 0);
            check("rst_mem_wstrb", mem_wstrb, 0);
            check("rst_owner", arb_owner, 1);   check("rst_locked", arb_locked, 0);
            inflight.delete();
            m_locked = 1'b0; m_owner = 1; m_cnt = '{0, 0}; m_rdata = '{32'h0, 32'h0};
        end else begin
            mreq  = {r1_req, r0_req};
            mwe   = {r1_we, r0_we};
            mlock = {r1_lock, r0_lock};
            maddr = '{r0_addr, r1_addr};
            mwd   = '{r0_wdata, r1_wdata};
            mws   = '{r0_wstrb, r1_wstrb};
            // who wins this cycle
            w = -1;
            if (!m_locked) begin
                if (mreq[0] && mreq[1]) w = 1 - m_owner;
                else if (mreq[0])       w = 0;
                else if (mreq[1])       w = 1;
            end else begin
                if (mreq[m_owner]) w = m_owner;
`ifdef MEM_ARB_STARVE_EN
                oth = 1 - m_owner;
                if (mreq[oth] && m_cnt[oth] >= SLIM) w = oth;
`endif
            end
            // reads due back this cycle
            ev = 2'b00;
            erd[0] = m_rdata[0];
            erd[1] = m_rdata[1];
            if (inflight.size() > 0 && inflight[0].due == cyc) begin
                ev[inflight[0].port]  = 1'b1;
                erd[inflight[0].port] = sram_word(inflight[0].addr);
                void'(inflight.pop_front());
            end
            check("r0_gnt", r0_gnt, w == 0);
            check("r1_gnt", r1_gnt, w == 1);
            check("mem_en", mem_en, w >= 0);
            check("mem_we", mem_we, (w >= 0) ? mwe[w] : 1'b0);
            check("mem_addr", mem_addr, (w >= 0) ? maddr[w] : 32'h0);
            check("mem_wdata", mem_wdata, (w >= 0) ? mwd[w] : 32'h0);
            check("mem_wstrb", mem_wstrb, (w >= 0) ? mws[w] : 4'h0);
            check("arb_owner", arb_owner, m_owner);
            check("arb_locked", arb_locked, m_locked);
            check("r0_rvalid", r0_rvalid, ev[0]);
            check("r1_rvalid", r1_rvalid, ev[1]);
            check("r0_rdata", r0_rdata, erd[0]);
            check("r1_rdata", r1_rdata, erd[1]);
            m_rdata[0] = erd[0];
            m_rdata[1] = erd[1];
            // advance the model to the next cycle
            for (int p = 0; p < 2; p++) begin
                if (w == p) m_cnt[p] = 0;
                else if (mreq[p] && m_cnt[p] < 255) m_cnt[p]++;
            end
            if (w >= 0) begin
                if (!mwe[w]) inflight.push_back('{w, maddr[w], cyc + LAT});
                m_owner  = w;
                m_locked = mlock[w];
            end else if (m_locked && !mreq[m_owner] && !mlock[m_owner]) begin
                m_locked = 1'b0;
            end
        end
        cyc++;
    end

    task automatic idle();
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0; r0_wstrb = '0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0; r1_wstrb = '0;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
    endtask

    logic [31:0] a0, a1;
    logic        g0, g1;

    initial begin
        idle();
        areset = 1'b1;
        #2;
        check("pin_rst_owner", arb_owner, 1);
        check("pin_rst_locked", arb_locked, 0);
        step();
        step();
        areset = 1'b0;

        // Both ports stream reads: alternating grants, LAT-cycle returns.
        a0 = 32'h1000;
        a1 = 32'h2000;
        for (int k = 0; k < 8; k++) begin
            r0_req = 1; r0_we = 0; r0_addr = a0;
            r1_req = 1; r1_we = 0; r1_addr = a1;
            #2;
            g0 = r0_gnt;
            g1 = r1_gnt;
            if (k == 0) begin
                check("pin_rr_first_r0", r0_gnt, 1);
                check("pin_rr_first_r1", r1_gnt, 0);
            end
            if (k == 1) check("pin_rr_second_r1", r1_gnt, 1);
            if (k == 2) begin
                check("pin_rr_ret_r0", r0_rvalid, 1);
                check("pin_rr_ret_data", r0_rdata, sram_word(32'h1000));
            end
            step();
            if (g0) a0 = a0 + 4;
            if (g1) a1 = a1 + 4;
        end
        idle();
        repeat (3) step();

        // Port 0 locked write burst while port 1 waits.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            r0_req = 1; r0_we = 1; r0_lock = (b < 3);
            r0_addr = 32'h4000_0000 + 32'(4 * b); r0_wdata = 32'hA0 + 32'(b); r0_wstrb = 4'hF;
            r1_req = 1; r1_we = 0; r1_addr = 32'h3000;
            #2;
            check("pin_burst_r0_gnt", r0_gnt, 1);
            check("pin_burst_r1_gnt", r1_gnt, 0);
            check("pin_burst_locked", arb_locked, b > 0);
            step();
        end
        r0_req = 0; r0_we = 0; r0_lock = 0;
        #2;
        check("pin_burst_after_r1", r1_gnt, 1);
        check("pin_burst_unlocked", arb_locked, 0);
        step();
        idle();
        repeat (3) step();

        // Port 1 read then port 0 read on consecutive cycles.
        r1_req = 1; r1_we = 0; r1_addr = 32'h5000;
        step();
        idle();
        r0_req = 1; r0_we = 0; r0_addr = 32'h6000;
        step();
        idle();
        #2;
        check("pin_order_r1_valid", r1_rvalid, 1);
        check("pin_order_r1_data", r1_rdata, sram_word(32'h5000));
        check("pin_order_r0_idle", r0_rvalid, 0);
        step();
        #2;
        check("pin_order_r0_valid", r0_rvalid, 1);
        check("pin_order_r0_data", r0_rdata, sram_word(32'h6000));
        check("pin_order_r1_idle", r1_rvalid, 0);
        step();
        repeat (2) step();

        // Reset in the middle of three reads.
        for (int k = 0; k < 3; k++) begin
            r0_req = 1; r0_we = 0; r0_addr = 32'h7000 + 32'(4 * k);
            if (k < 2) step();
        end
        #1;
        areset = 1'b1;
        #1;
        check("pin_midrst_gnt", r0_gnt, 0);
        check("pin_midrst_mem_en", mem_en, 0);
        check("pin_midrst_addr", mem_addr, 0);
        check("pin_midrst_rvalid", r0_rvalid, 0);
        check("pin_midrst_owner", arb_owner, 1);
        step();
        idle();
        step();
        areset = 1'b0;
        repeat (4) step();

        // Port 0 holds its lock while port 1 keeps requesting.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            r0_req = 1; r0_we = 1; r0_lock = 1; r0_addr = 32'h8000;
            r0_wdata = 32'(k); r0_wstrb = 4'hF;
            r1_req = 1; r1_we = 0; r1_addr = 32'h9000;
            #2;
`ifdef MEM_ARB_STARVE_EN
            if (k == SLIM) check("pin_starve_override", r1_gnt, 1);
`else
            check("pin_hold_r1_blocked", r1_gnt, 0);
            if (k > 0) check("pin_hold_locked", arb_locked, 1);
`endif
            step();
        end
        r0_req = 0; r0_lock = 0;
        r1_req = 1; r1_we = 0; r1_addr = 32'h9000;
`ifndef MEM_ARB_STARVE_EN
        #2;
        check("pin_release_still_blocked", r1_gnt, 0);
`endif
        step();
`ifndef MEM_ARB_STARVE_EN
        #2;
        check("pin_release_r1_gnt", r1_gnt, 1);
        check("pin_release_unlocked", arb_locked, 0);
`endif
        step();
        idle();
        repeat (3) step();

        // Single port 1 partial write.
        r1_req = 1; r1_we = 1; r1_addr = 32'hA000; r1_wdata = 32'h1122_3344; r1_wstrb = 4'b0101;
        #2;
        check("pin_wr_gnt", r1_gnt, 1);
        check("pin_wr_mem_en", mem_en, 1);
        check("pin_wr_mem_we", mem_we, 1);
        check("pin_wr_wstrb", mem_wstrb, 4'b0101);
        check("pin_wr_wdata", mem_wdata, 32'h1122_3344);
        step();
        idle();
        repeat (3) step();

        // lock without req must not take the lock.
        r0_lock = 1;
        step();
        #2;
        check("pin_lock_no_req", arb_locked, 0);
        step();
        idle();
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
